// File: rtl/proc_nreg.sv
// Multi-cycle processor core: shared bus, NREGS general registers, accumulator A and result G.
// Executes mv, mvi, add, sub, and, mvnz over time steps T0..T3 with a Run/Done handshake.
module proc_nreg #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Run,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic [DATA_W-1:0] IR,
  output logic [1:0]        Tstep
);

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;
  typedef enum logic [2:0] {SEL_NONE, SEL_DIN, SEL_RX, SEL_RY, SEL_G} bus_sel_t;

  step_t             step_reg, step_next;
  bus_sel_t          bus_sel;
  logic [DATA_W-1:0] ir_reg, a_reg, g_reg;
  logic [DATA_W-1:0] alu_res;
  logic              ir_we, a_we, g_we, rx_we, done_c;

  logic [2:0] op, x_idx, y_idx;
  assign op    = ir_reg[DATA_W-1 -: 3];
  assign x_idx = ir_reg[DATA_W-4 -: 3];
  assign y_idx = ir_reg[DATA_W-7 -: 3];

  // Read view over all eight encodable indices; indices past NREGS read as zero
  // and have no storage, so writes to them simply vanish.
  logic [DATA_W-1:0] rd_view [8];
  logic [DATA_W-1:0] rx_val, ry_val;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_gpr
      if (gi < NREGS) begin : g_live
        logic [DATA_W-1:0] q;
        always_ff @(posedge Clock or negedge Resetn) begin
          if (!Resetn) begin
            q <= '0;
          end else if (rx_we && (x_idx == 3'(gi))) begin
            q <= BusWires;
          end
        end
        assign rd_view[gi] = q;
      end else begin : g_absent
        assign rd_view[gi] = '0;
      end
    end
  endgenerate

  assign rx_val = rd_view[x_idx];
  assign ry_val = rd_view[y_idx];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_reg <= T0;
      ir_reg   <= '0;
      a_reg    <= '0;
      g_reg    <= '0;
    end else begin
      step_reg <= step_next;
      if (ir_we) ir_reg <= BusWires;
      if (a_we)  a_reg  <= BusWires;
      if (g_we)  g_reg  <= alu_res;
    end
  end

  always_comb begin
    step_next = step_reg;
    bus_sel   = SEL_NONE;
    ir_we     = 1'b0;
    a_we      = 1'b0;
    g_we      = 1'b0;
    rx_we     = 1'b0;
    done_c    = 1'b0;
    case (step_reg)
      T0: begin
        bus_sel = SEL_DIN;
        if (Run) begin
          ir_we     = 1'b1;
          step_next = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            bus_sel   = SEL_RY;
            rx_we     = 1'b1;
            done_c    = 1'b1;
            step_next = T0;
          end
          OP_MVI: begin
            bus_sel   = SEL_DIN;
            rx_we     = 1'b1;
            done_c    = 1'b1;
            step_next = T0;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            bus_sel   = SEL_RX;
            a_we      = 1'b1;
            step_next = T2;
          end
          OP_MVNZ: begin
            bus_sel   = SEL_RY;
            rx_we     = (g_reg != '0);
            done_c    = 1'b1;
            step_next = T0;
          end
          default: begin
            done_c    = 1'b1;
            step_next = T0;
          end
        endcase
      end
      T2: begin
        bus_sel   = SEL_RY;
        g_we      = 1'b1;
        step_next = T3;
      end
      T3: begin
        bus_sel   = SEL_G;
        rx_we     = 1'b1;
        done_c    = 1'b1;
        step_next = T0;
      end
      default: step_next = T0;
    endcase
  end

  always_comb begin
    BusWires = '0;
    case (bus_sel)
      SEL_DIN: BusWires = DIN;
      SEL_RX:  BusWires = rx_val;
      SEL_RY:  BusWires = ry_val;
      SEL_G:   BusWires = g_reg;
      default: BusWires = '0;
    endcase
  end

  // Only reached in T2, where the bus carries Ry.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_reg + BusWires;
      OP_SUB:  alu_res = a_reg - BusWires;
      OP_AND:  alu_res = a_reg & BusWires;
      default: alu_res = '0;
    endcase
  end

  assign Done  = done_c;
  assign IR    = ir_reg;
  assign Tstep = step_reg;

endmodule

// File: tb/tb_proc_nreg.sv
// Bench for proc_nreg: an NREGS=8 and an NREGS=2 instance share stimulus and are checked
// every cycle against an instruction-level model; a vector table holds hand-derived results.
module tb_proc_nreg;

  logic        Clock;
  logic        Resetn;
  logic [15:0] DIN;
  logic        Run;
  logic        done8, done2;
  logic [15:0] bus8, bus2, ir8, ir2;
  logic [1:0]  ts8, ts2;

  proc_nreg #(.DATA_W(16), .NREGS(8)) dut8 (
    .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Run(Run),
    .Done(done8), .BusWires(bus8), .IR(ir8), .Tstep(ts8)
  );

  proc_nreg #(.DATA_W(16), .NREGS(2)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Run(Run),
    .Done(done2), .BusWires(bus2), .IR(ir2), .Tstep(ts2)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int vectors = 0;
  int miscompares = 0;

  // Architectural model: index 0 is the 8-register core, index 1 the 2-register core.
  int          nregs [2] = '{8, 2};
  logic [15:0] m_r [2][8];
  logic [15:0] m_a [2];
  logic [15:0] m_g [2];
  logic [15:0] m_ir;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_r[k][i] = '0;
      m_a[k] = '0;
      m_g[k] = '0;
    end
    m_ir = '0;
  endtask

  function automatic logic [15:0] rd(input int k, input logic [2:0] idx);
    return (int'(idx) < nregs[k]) ? m_r[k][idx] : 16'h0000;
  endfunction

  task automatic wr(input int k, input logic [2:0] idx, input logic [15:0] v);
    if (int'(idx) < nregs[k]) m_r[k][idx] = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: compare at the falling edge, then advance to just after the rising edge.
  task automatic step(input logic [1:0] ts, input logic [15:0] e8, input logic [15:0] e2,
                      input logic ed, input logic [15:0] eir,
                      inout int cyc, inout logic [15:0] gb, inout int gl);
    @(negedge Clock);
    cyc++;
    chk("tstep8", 32'(ts8), 32'(ts));
    chk("tstep2", 32'(ts2), 32'(ts));
    chk("bus8", 32'(bus8), 32'(e8));
    chk("bus2", 32'(bus2), 32'(e2));
    chk("done8", 32'(done8), 32'(ed));
    chk("done2", 32'(done2), 32'(ed));
    chk("ir8", 32'(ir8), 32'(eir));
    chk("ir2", 32'(ir2), 32'(eir));
    if (done8 && gl == 0) begin
      gl = cyc;
      gb = bus8;
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic async_abort();
    #2 Resetn = 1'b0;
    #1;
    chk("abort_tstep8", 32'(ts8), 32'd0);
    chk("abort_tstep2", 32'(ts2), 32'd0);
    chk("abort_done8", 32'(done8), 32'd0);
    chk("abort_done2", 32'(done2), 32'd0);
    chk("abort_ir8", 32'(ir8), 32'd0);
    chk("abort_ir2", 32'(ir2), 32'd0);
    chk("abort_bus8", 32'(bus8), 32'(DIN));
    model_reset();
    @(posedge Clock);
    @(posedge Clock);
    #1 Resetn = 1'b1;
    Run = 1'b0;
  endtask

  // Runs one instruction from T0 to Done; reports the 8-register bus at Done and the
  // cycle count T0..Done. abort_at == 2 pulls reset in T2 and returns early.
  task automatic exec(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                      input logic [6:0] rest, input logic [15:0] imm, input int abort_at,
                      output logic [15:0] gb, output int gl);
    logic [15:0] instr;
    logic [15:0] eb [2];
    int cyc;
    instr = {op, x, y, rest};
    gb = '0;
    gl = 0;
    cyc = 0;
    DIN = instr;
    Run = 1'b1;
    step(2'd0, instr, instr, 1'b0, m_ir, cyc, gb, gl);
    m_ir = instr;
    Run = 1'($urandom);
    DIN = (op == 3'd1) ? imm : 16'($urandom);
    case (op)
      3'd0, 3'd5: begin
        for (int k = 0; k < 2; k++) eb[k] = rd(k, y);
        step(2'd1, eb[0], eb[1], 1'b1, instr, cyc, gb, gl);
        for (int k = 0; k < 2; k++)
          if (op == 3'd0 || m_g[k] != 16'h0000) wr(k, x, eb[k]);
      end
      3'd1: begin
        step(2'd1, imm, imm, 1'b1, instr, cyc, gb, gl);
        for (int k = 0; k < 2; k++) wr(k, x, imm);
      end
      3'd2, 3'd3, 3'd4: begin
        for (int k = 0; k < 2; k++) begin
          eb[k] = rd(k, x);
          m_a[k] = eb[k];
        end
        step(2'd1, eb[0], eb[1], 1'b0, instr, cyc, gb, gl);
        if (abort_at == 2) begin
          async_abort();
          return;
        end
        Run = 1'($urandom);
        DIN = 16'($urandom);
        for (int k = 0; k < 2; k++) begin
          eb[k] = rd(k, y);
          if (op == 3'd2)      m_g[k] = m_a[k] + eb[k];
          else if (op == 3'd3) m_g[k] = m_a[k] - eb[k];
          else                 m_g[k] = m_a[k] & eb[k];
        end
        step(2'd2, eb[0], eb[1], 1'b0, instr, cyc, gb, gl);
        Run = 1'($urandom);
        DIN = 16'($urandom);
        step(2'd3, m_g[0], m_g[1], 1'b1, instr, cyc, gb, gl);
        for (int k = 0; k < 2; k++) wr(k, x, m_g[k]);
      end
      default: begin
        step(2'd1, 16'h0000, 16'h0000, 1'b1, instr, cyc, gb, gl);
      end
    endcase
    Run = 1'b0;
  endtask

  task automatic idle(input int n);
    int cyc;
    logic [15:0] gb;
    int gl;
    cyc = 0;
    gb = '0;
    gl = 0;
    Run = 1'b0;
    for (int i = 0; i < n; i++) begin
      DIN = 16'($urandom);
      step(2'd0, DIN, DIN, 1'b0, m_ir, cyc, gb, gl);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [15:0] imm;
    logic [15:0] exp_bus;
    int          exp_lat;
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [15:0] gb;
    int gl;
    logic [2:0] rop;

    tbl[0]  = '{3'd1, 3'd0, 3'd0, 16'h0005, 16'h0005, 2};
    tbl[1]  = '{3'd1, 3'd1, 3'd0, 16'h0003, 16'h0003, 2};
    tbl[2]  = '{3'd2, 3'd0, 3'd1, 16'h0000, 16'h0008, 4};
    tbl[3]  = '{3'd0, 3'd0, 3'd0, 16'h0000, 16'h0008, 2};
    tbl[4]  = '{3'd3, 3'd1, 3'd0, 16'h0000, 16'hFFFB, 4};
    tbl[5]  = '{3'd0, 3'd1, 3'd1, 16'h0000, 16'hFFFB, 2};
    tbl[6]  = '{3'd1, 3'd2, 3'd0, 16'hFFFF, 16'hFFFF, 2};
    tbl[7]  = '{3'd1, 3'd3, 3'd0, 16'h0001, 16'h0001, 2};
    tbl[8]  = '{3'd2, 3'd2, 3'd3, 16'h0000, 16'h0000, 4};
    tbl[9]  = '{3'd5, 3'd4, 3'd3, 16'h0000, 16'h0001, 2};
    tbl[10] = '{3'd0, 3'd4, 3'd4, 16'h0000, 16'h0000, 2};
    tbl[11] = '{3'd1, 3'd0, 3'd0, 16'h00F0, 16'h00F0, 2};
    tbl[12] = '{3'd1, 3'd1, 3'd0, 16'h0FF0, 16'h0FF0, 2};
    tbl[13] = '{3'd4, 3'd0, 3'd1, 16'h0000, 16'h00F0, 4};
    tbl[14] = '{3'd5, 3'd5, 3'd1, 16'h0000, 16'h0FF0, 2};
    tbl[15] = '{3'd0, 3'd5, 3'd5, 16'h0000, 16'h0FF0, 2};
    tbl[16] = '{3'd7, 3'd2, 3'd3, 16'h0000, 16'h0000, 2};
    tbl[17] = '{3'd0, 3'd0, 3'd0, 16'h0000, 16'h00F0, 2};
    tbl[18] = '{3'd3, 3'd3, 3'd3, 16'h0000, 16'h0000, 4};
    tbl[19] = '{3'd2, 3'd0, 3'd0, 16'h0000, 16'h01E0, 4};
    tbl[20] = '{3'd0, 3'd3, 3'd3, 16'h0000, 16'h0000, 2};

    Resetn = 1'b0;
    Run = 1'b0;
    DIN = 16'h1234;
    model_reset();
    @(negedge Clock);
    chk("rst_tstep8", 32'(ts8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_ir8", 32'(ir8), 32'd0);
    chk("rst_bus8", 32'(bus8), 32'h1234);
    chk("rst_ir2", 32'(ir2), 32'd0);
    @(posedge Clock);
    #1 Resetn = 1'b1;

    for (int i = 0; i < 21; i++) begin
      exec(tbl[i].op, tbl[i].x, tbl[i].y, 7'd0, tbl[i].imm, 0, gb, gl);
      $display("vec %0d op=%0d x=%0d y=%0d bus_at_done=%h lat=%0d", i, tbl[i].op, tbl[i].x,
               tbl[i].y, gb, gl);
      chk("tbl_bus", 32'(gb), 32'(tbl[i].exp_bus));
      chk("tbl_lat", 32'(gl), 32'(tbl[i].exp_lat));
    end

    idle(5);
    $display("idle 5 cycles with Run low");

    exec(3'd2, 3'd0, 3'd1, 7'd0, 16'h0000, 2, gb, gl);
    $display("add aborted by reset in T2");
    for (int i = 0; i < 8; i++) begin
      exec(3'd0, 3'(i), 3'(i), 7'd0, 16'h0000, 0, gb, gl);
      $display("readback R%0d after abort = %h", i, gb);
      chk("abort_reg", 32'(gb), 32'd0);
    end
    exec(3'd1, 3'd1, 3'd0, 7'd0, 16'h0007, 0, gb, gl);
    exec(3'd5, 3'd0, 3'd1, 7'd0, 16'h0000, 0, gb, gl);
    exec(3'd0, 3'd0, 3'd0, 7'd0, 16'h0000, 0, gb, gl);
    $display("mvnz with cleared G then readback R0 = %h", gb);
    chk("abort_g_clear", 32'(gb), 32'd0);

    for (int i = 0; i < 200; i++) begin
      rop = 3'($urandom_range(0, 7));
      exec(rop, 3'($urandom), 3'($urandom), 7'($urandom), 16'($urandom), 0, gb, gl);
      $display("rnd %0d op=%0d ir=%h bus_at_done=%h lat=%0d", i, rop, m_ir, gb, gl);
      chk("rnd_lat", 32'(gl), (rop >= 3'd2 && rop <= 3'd4) ? 32'd4 : 32'd2);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
